// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the single-port synchronous
// data SRAM of the MIPS core. Requester 0 is the CPU data port and requester 1
// is the loader/debug port. Every memory strobe comes from a register, and each
// port has a saturating grant counter for bring-up.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin on contention (last-grant pointer)
//                   undefined -> fixed priority, port 0 wins contention
module dmem_arbiter #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    input  logic          cnt_clr,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic          CEN,
    output logic          WEN,
    output logic          OEN,
    output logic [AW-1:0] A,
    output logic [DW-1:0] D,
    input  logic [DW-1:0] Q
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state, state_nxt;

    logic          start;      // a request is accepted this cycle
    logic          sel1;       // port 1 wins the current arbitration
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    logic          acc_we;     // direction of the access in flight
    logic          gnt0_q, gnt1_q;
    logic          rv0_q, rv1_q;
    logic          cen_q, wen_q, oen_q;
    logic [AW-1:0] a_q;
    logic [DW-1:0] d_q;
    logic [CW-1:0] cnt0_q, cnt1_q;

`ifdef DMEM_ARB_RR_EN
    logic          last1;      // 1 = port 1 received the most recent grant

    // Last-grant pointer; reset to port 1 so port 0 wins the first contention.
    always_ff @(posedge CLK) begin
        if (RST)
            last1 <= 1'b1;
        else if (start)
            last1 <= sel1;
    end
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and arbitration decision; ACCESS always lasts one cycle.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        sel1      = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    start     = 1'b1;
`ifdef DMEM_ARB_RR_EN
                    sel1      = m1_req && (!m0_req || !last1);
`else
                    sel1      = !m0_req;
`endif
                    state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = IDLE;
        endcase
    end

    assign w_we    = sel1 ? m1_we    : m0_we;
    assign w_addr  = sel1 ? m1_addr  : m0_addr;
    assign w_wdata = sel1 ? m1_wdata : m0_wdata;

    // Memory strobes, grant and read-valid pulses, all registered.
    // The strobes are loaded on the arbitration edge so they are live exactly
    // during ACCESS; rvalid is derived from the grant one edge later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
            cen_q  <= 1'b1;
            wen_q  <= 1'b1;
            oen_q  <= 1'b1;
            a_q    <= '0;
            d_q    <= '0;
            acc_we <= 1'b0;
        end else begin
            gnt0_q <= start && !sel1;
            gnt1_q <= start && sel1;
            rv0_q  <= gnt0_q && !acc_we;
            rv1_q  <= gnt1_q && !acc_we;
            cen_q  <= !start;
            wen_q  <= !(start && w_we);
            oen_q  <= !(start && !w_we);
            if (start) begin
                a_q    <= w_addr;
                acc_we <= w_we;
                if (w_we)
                    d_q <= w_wdata;
            end
        end
    end

    // Saturating grant counters; clear beats a same-cycle increment.
    always_ff @(posedge CLK) begin
        if (RST || cnt_clr) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (start && !sel1 && (cnt0_q != '1))
                cnt0_q <= cnt0_q + 1'b1;
            if (start && sel1 && (cnt1_q != '1))
                cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign m0_gnt    = gnt0_q;
    assign m1_gnt    = gnt1_q;
    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;
    assign m0_rdata  = Q;
    assign m1_rdata  = Q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;
    assign CEN       = cen_q;
    assign WEN       = wen_q;
    assign OEN       = oen_q;
    assign A         = a_q;
    assign D         = d_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous SRAM and a
// read-response scoreboard. Counter width is 2 so saturation is reachable.
module tb_dmem_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          m0_req, m0_we, m1_req, m1_we, cnt_clr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [CW-1:0] cnt0, cnt1;
    logic          CEN, WEN, OEN;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [DW-1:0] Q;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } rd_t;

    rd_t  exp_q[$];
    rd_t  mon_e;
    logic [1:0] mon_ep;
    logic [1:0] exp_g [0:3];
    int   n_pass  = 0;
    int   n_total = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .CLK(CLK), .RST(RST),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1),
        .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D), .Q(Q)
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port SRAM: write at the access edge, Q valid next cycle.
    always @(posedge CLK) begin
        if (!CEN) begin
            if (!WEN)
                mem[A] <= D;
            else if (!OEN)
                Q <= mem[A];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    // Read-response monitor: every rvalid must match the oldest expected read.
    always @(negedge CLK) begin
        if (m0_rvalid || m1_rvalid) begin
            if (exp_q.size() > 0) begin
                mon_e  = exp_q.pop_front();
                mon_ep = mon_e.port ? 2'b10 : 2'b01;
            end else begin
                mon_e  = '0;
                mon_ep = 2'b00;
            end
            chk("rvalid port", {m1_rvalid, m0_rvalid}, mon_ep);
            chk("rdata", mon_e.port ? m1_rdata : m0_rdata, mon_e.data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        cnt_clr = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 + i;
        mem[5]  = 32'hDEAD_BEEF;
        mem[10] = 32'hA0A0_0010;
        mem[20] = 32'hB1B1_0020;

        // Reset state
        cyc(); cyc(); at_neg();
        chk("rst CEN", CEN, 1); chk("rst WEN", WEN, 1); chk("rst OEN", OEN, 1);
        chk("rst A", A, 0); chk("rst D", D, 0);
        chk("rst gnt", {m1_gnt, m0_gnt}, 0); chk("rst rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("rst cnt", {cnt1, cnt0}, 0);
        cyc(); RST = 0;
        cyc();

        // Single read by m0 of addr 5
        m0_req = 1; m0_we = 0; m0_addr = 5;
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        cyc(); m0_req = 0; at_neg();
        chk("rd gnt", {m1_gnt, m0_gnt}, 2'b01);
        chk("rd CEN", CEN, 0); chk("rd OEN", OEN, 0); chk("rd WEN", WEN, 1);
        chk("rd A", A, 5); chk("rd early rvalid", m0_rvalid, 0);
        cyc(); at_neg();
        chk("rd rvalid", m0_rvalid, 1); chk("rd gnt drop", m0_gnt, 0);
        chk("rd CEN idle", CEN, 1); chk("rd cnt0", cnt0, 1);

        // Write by m1 to addr 127
        cyc();
        m1_req = 1; m1_we = 1; m1_addr = 127; m1_wdata = 32'h1234_5678;
        cyc(); m1_req = 0; at_neg();
        chk("wr gnt", {m1_gnt, m0_gnt}, 2'b10);
        chk("wr CEN", CEN, 0); chk("wr WEN", WEN, 0); chk("wr OEN", OEN, 1);
        chk("wr A", A, 127); chk("wr D", D, 32'h1234_5678); chk("wr cnt1", cnt1, 1);
        cyc(); at_neg();
        chk("wr no rvalid", {m1_rvalid, m0_rvalid}, 0); chk("wr WEN idle", WEN, 1);

        // Read-back by m0; D keeps the last written value
        cyc();
        m0_req = 1; m0_we = 0; m0_addr = 127;
        exp_q.push_back({1'b0, 32'h1234_5678});
        cyc(); m0_req = 0; at_neg();
        chk("rb gnt", m0_gnt, 1); chk("rb A", A, 127); chk("rb OEN", OEN, 0);
        chk("rb D hold", D, 32'h1234_5678);
        cyc(); at_neg();
        chk("rb rvalid", m0_rvalid, 1);

        // Contention: both ports read continuously for 8 cycles after a reset
`ifdef DMEM_ARB_RR_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
        cyc(); RST = 1;
        cyc(); RST = 0;
        m0_req = 1; m0_we = 0; m0_addr = 10;
        m1_req = 1; m1_we = 0; m1_addr = 20;
        for (int k = 0; k < 4; k++) begin
            if (exp_g[k] == 2'b10) exp_q.push_back({1'b1, 32'hB1B1_0020});
            else                   exp_q.push_back({1'b0, 32'hA0A0_0010});
        end
        for (int i = 0; i < 8; i++) begin
            at_neg();
            chk($sformatf("cont gnt c%0d", i), {m1_gnt, m0_gnt},
                (i % 2 == 1) ? exp_g[i/2] : 2'b00);
            cyc();
        end
        m0_req = 0; m1_req = 0;
        at_neg();
`ifdef DMEM_ARB_RR_EN
        chk("cont cnt0", cnt0, 2); chk("cont cnt1", cnt1, 2);
`else
        // four port-0 grants saturate the 2-bit counter at 3
        chk("cont cnt0", cnt0, 3); chk("cont cnt1", cnt1, 0);
`endif

        // Reset asserted during the ACCESS of a read drops gnt/rvalid
        cyc();
        m0_req = 1; m0_we = 0; m0_addr = 5;
        cyc(); m0_req = 0; RST = 1; at_neg();
        chk("mid gnt", m0_gnt, 1);
        cyc(); RST = 0;
        m1_req = 1; m1_we = 1; m1_addr = 3; m1_wdata = 32'h0000_0055;
        at_neg();
        chk("mid strobes", {CEN, WEN, OEN}, 3'b111);
        chk("mid no rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("mid no gnt", {m1_gnt, m0_gnt}, 0);
        chk("mid cnt", {cnt1, cnt0}, 0);
        cyc(); m1_req = 0; at_neg();
        chk("mid idle regrant", {m1_gnt, m0_gnt}, 2'b10);

        // Saturation: five back-to-back m0 writes with CW=2
        cyc();
        m0_req = 1; m0_we = 1; m0_addr = 0; m0_wdata = 32'h77;
        for (int i = 0; i < 10; i++) cyc();
        m0_req = 0;
        at_neg();
        chk("sat cnt0", cnt0, 3); chk("sat cnt1", cnt1, 1);

        // Clear coincident with a grant wins over the increment
        cyc();
        m0_req = 1; cnt_clr = 1;
        cyc(); m0_req = 0; cnt_clr = 0; at_neg();
        chk("clr gnt", m0_gnt, 1); chk("clr cnt0", cnt0, 0); chk("clr cnt1", cnt1, 0);
        cyc();
        m0_req = 1;
        cyc(); m0_req = 0; at_neg();
        chk("post clr gnt", m0_gnt, 1); chk("post clr cnt0", cnt0, 1);

        cyc(); cyc(); at_neg();
        chk("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port synchronous data memory of the MIPS core. It shares one CEN/WEN/OEN/A/D/Q SRAM between requester 0 (CPU data port) and requester 1 (loader/debug port) using a req/gnt/rvalid handshake. All memory-side strobes are driven from registers, and the block keeps saturating per-port grant counters for bring-up.

## Interface
Parameters:
- AW, 7, memory word-address width
- DW, 32, data width
- CW, 16, grant-counter width

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high
- m0_req / m1_req  in  1  access request; held with command fields until gnt is seen
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  word address
- m0_wdata / m1_wdata  in  DW  write data
- m0_gnt / m1_gnt  out  1  one-cycle grant pulse, registered
- m0_rvalid / m1_rvalid  out  1  one-cycle read-data-valid pulse, registered
- m0_rdata / m1_rdata  out  DW  equal to Q; meaningful only while the matching rvalid is high
- cnt_clr  in  1  synchronous clear of both grant counters
- cnt0 / cnt1  out  CW  saturating grant counts for each port
- CEN  out  1  memory chip enable, active-low, registered
- WEN  out  1  memory write enable, active-low, registered
- OEN  out  1  memory output enable, active-low, registered
- A  out  AW  memory address, registered
- D  out  DW  memory write data, registered
- Q  in  DW  memory read data; valid the cycle after a read access

## Operation
- FSM has two states:
  - IDLE: arbitrate. If any req is high, latch the winner's command and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: exactly one cycle, then return to IDLE unconditionally. req is ignored in this state.
- Outputs during ACCESS:
  - CEN=0, A=winner addr, winner gnt=1.
  - Read: OEN=0, WEN=1.
  - Write: WEN=0, OEN=1, D=winner wdata.
- Outputs outside ACCESS: CEN=1, WEN=1, OEN=1. A and D hold their last value; both are 0 after reset.
- Read response: winner rvalid=1 in the cycle after ACCESS, and rdata=Q in that cycle.
- Writes produce no rvalid.
- Only one request is served per grant. A req still high in IDLE after its gnt is a new transaction.
- Arbitration when both ports request is decided by DMEM_ARB_RR_EN (see Configuration). A lone requester always wins.
- Counters: cntX increments on each grant to port X and saturates at 2^CW-1.
  - cnt_clr forces both counters to 0.
  - cnt_clr has priority over a same-cycle increment.
- Reset values: state=IDLE, CEN=WEN=OEN=1, A=0, D=0, gnt=0, rvalid=0, cnt=0, last-grant pointer=1 (so port 0 wins the first contention).
- Reset asserted during ACCESS or during an rvalid cycle takes effect at that edge: the pending gnt/rvalid is dropped, no retry is made, and the requester must re-request.

## Timing
- Request sampled in IDLE cycle N → ACCESS plus gnt in N+1 → rvalid plus Q in N+2 (reads).
- The next grant can occur at N+3 at the earliest.
- Sustained throughput is one access per 2 cycles. Read latency from the first request cycle is 2.
- The write is committed by the SRAM at the end of N+1.
- rvalid of one transaction may coincide with the IDLE arbitration cycle of the next. The two never conflict.
- When both ports request in the same IDLE cycle, exactly one gnt pulses. The loser's req stays pending and wins the following IDLE cycle, provided the winner does not re-request under fixed priority.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. On contention the port not granted last wins. The last-grant pointer updates on every grant.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins contention, and port 1 can starve. The pointer register is not built.

## Test plan
- Reset then single read: preload addr 5 = 0xDEADBEEF; m0 reads addr 5 at N → m0_gnt at N+1 with CEN=0, OEN=0, A=5 → m0_rvalid at N+2, m0_rdata=0xDEADBEEF, cnt0=1.
- Write then read-back via the other port: m1 writes 0x12345678 to addr 127 → WEN=0, D=0x12345678 during its ACCESS, no rvalid. m0 then reads addr 127 → 0x12345678.
- Contention with both req held 8 cycles:
  - RR_EN: grants alternate m0, m1, m0, m1 at 2-cycle spacing, cnt0=cnt1=2.
  - Without RR_EN: four m0 grants, cnt1=0.
- Reset mid-operation: RST asserted during ACCESS of a read → next cycle CEN=WEN=OEN=1, no rvalid, state IDLE, counters 0.
- Counter saturation and clear: CW=2, five m0 grants → cnt0=3. cnt_clr coincident with a grant → cnt0=0.
